div16by8: RTL and testbench
===========================

DIV16BY8 -- requirements
Module: div16by8

Sequential unsigned divider; inverse of the 8x8 multiply path (divides a 16-bit product {high,low} by an 8-bit operand).

Interface
REQ-001 The port clk, input, 1 bit, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-002 The port rst_n, input, 1 bit, SHALL be the asynchronous, active-low reset.
REQ-003 The port Start, input, 1 bit, SHALL request a division; it SHALL be sampled only in IDLE.
REQ-004 The port DH, input, 8 bits, SHALL be the dividend high byte.
REQ-005 The port DL, input, 8 bits, SHALL be the dividend low byte.
REQ-006 The port Divisor, input, 8 bits, SHALL be the unsigned divisor.
REQ-007 The port Q, output, 8 bits, SHALL be the registered quotient.
REQ-008 The port R, output, 8 bits, SHALL be the registered remainder.
REQ-009 The port O, output, 1 bit, SHALL be the registered overflow/error flag for the last operation.
REQ-010 The port Busy, output, 1 bit, SHALL be high while a division is in progress (RUN state).
REQ-011 The port Done, output, 1 bit, SHALL be a one-cycle completion pulse (DONE state).

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 In IDLE with Start=1, the block SHALL capture DH, DL and Divisor into internal registers at that edge (edge 0).
REQ-014 At edge 0, if Divisor==0 or DH>=Divisor, the block SHALL go to DONE and set O=1, Q=8'hFF and R=8'h00; RUN SHALL be skipped.
REQ-015 At edge 0 with valid operands, the block SHALL go to RUN, set the 9-bit partial remainder to {0,DH}, clear the 3-bit iteration counter and clear O.
REQ-016 Each RUN edge SHALL perform one restoring step, MSB of DL first:
- rem = {rem[7:0], next DL bit};
- if rem>=Divisor, then rem -= Divisor and the quotient bit is 1;
- otherwise the quotient bit is 0.
REQ-017 The partial remainder SHALL be 9 bits wide, so that no intermediate value is truncated.
REQ-018 After the 8th RUN edge (edge 8), the block SHALL load Q and R from the final quotient and remainder and go to DONE.
REQ-019 The result SHALL satisfy {DH,DL} = Q*Divisor + R with R<Divisor.
REQ-020 Done SHALL be high for exactly one cycle in DONE.
- Valid operation: Done is high between edge 8 and edge 9.
- Error operation: Done is high between edge 0 and edge 1.
REQ-021 DONE SHALL return to IDLE unconditionally on the next edge.
REQ-022 Busy SHALL be 1 only in RUN; Busy and Done SHALL never be high together.
REQ-023 Start SHALL be ignored in RUN and DONE; it SHALL not be queued.
REQ-024 A new start SHALL be accepted at the earliest on the edge after DONE, once the block is back in IDLE.
REQ-025 Input changes during RUN SHALL NOT affect the result, since operands are captured at edge 0.
REQ-026 Q, R and O SHALL hold their values from DONE until the next accepted Start.
REQ-027 Q and R SHALL NOT change during RUN; intermediates SHALL be kept in internal registers.
REQ-028 All outputs SHALL be driven from registers, with no combinational path from inputs to outputs.

Reset
REQ-029 While rst_n=0, the block SHALL immediately force:
- state to IDLE;
- Q=8'h00, R=8'h00, O=0, Busy=0, Done=0;
- counter and partial remainder to 0.
REQ-030 Reset asserted mid-RUN SHALL abort the operation; no Done pulse SHALL follow.
REQ-031 The first Start after rst_n deasserts SHALL be accepted normally.

Verification
REQ-032 The bench SHALL cover Start with DH=8'h03, DL=8'hE8, Divisor=7 (1000/7):
- Busy=1 for 8 cycles;
- then Done=1 for one cycle with Q=8'h8E, R=8'h06, O=0.
REQ-033 The bench SHALL cover DH=8'hFE, DL=8'h01, Divisor=8'hFF: -> Q=8'hFF, R=8'h00, O=0 at Done.
REQ-034 The bench SHALL cover Divisor=0 (any dividend), and separately DH=8'hFF with Divisor=8'hFF:
- Done one cycle after Start, Busy never high;
- O=1, Q=8'hFF, R=8'h00.
REQ-035 The bench SHALL cover Start re-pulsed with different operands during RUN and DONE:
- the original result is unaffected;
- exactly one Done pulse occurs;
- the next IDLE Start is accepted.
REQ-036 The bench SHALL cover rst_n pulsed low in the 4th RUN cycle:
- outputs are 0 immediately;
- no Done pulse;
- a subsequent 1000/7 still gives 8'h8E / 8'h06.
REQ-037 The bench SHALL cover a random sweep of 10,000 operands checked against a reference model:
- Q*Divisor+R == {DH,DL} and R<Divisor for every non-error case;
- O=1 exactly when Divisor==0 or DH>=Divisor.

Source files
------------

// File: rtl/div16by8.sv
// Sequential unsigned 16-by-8 restoring divider: {DH,DL} / Divisor -> Q, R, O.
// One quotient bit per cycle; overflow and divide-by-zero are flagged without iterating.
module div16by8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       Start,
  input  logic [7:0] DH,
  input  logic [7:0] DL,
  input  logic [7:0] Divisor,
  output logic [7:0] Q,
  output logic [7:0] R,
  output logic       O,
  output logic       Busy,
  output logic       Done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0] r_state;
  logic [7:0] r_dl;
  logic [7:0] r_div;
  logic [8:0] r_rem;
  logic [6:0] r_quo;
  logic [2:0] r_cnt;
  logic [7:0] r_q;
  logic [7:0] r_r;
  logic       r_o;

  logic [8:0] w_shift;
  logic [8:0] w_diff;
  logic [8:0] w_rem_next;
  logic       w_ge;

  // Bit 8 of the remainder can never be set after a restoring step, but folding
  // it into the compare keeps the comparison exact over the full 10-bit value.
  assign w_shift    = {r_rem[7:0], r_dl[7]};
  assign w_ge       = r_rem[8] | (w_shift >= {1'b0, r_div});
  assign w_diff     = w_shift - {1'b0, r_div};
  assign w_rem_next = w_ge ? w_diff : w_shift;

  // NOTE: every register, datapath included, is reset so an aborted division leaves no residue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_dl    <= 8'h00;
      r_div   <= 8'h00;
      r_rem   <= 9'h000;
      r_quo   <= 7'h00;
      r_cnt   <= 3'd0;
      r_q     <= 8'h00;
      r_r     <= 8'h00;
      r_o     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_dl  <= DL;
            r_div <= Divisor;
            if (Divisor == 8'h00 || DH >= Divisor) begin
              r_o     <= 1'b1;
              r_q     <= 8'hFF;
              r_r     <= 8'h00;
              r_state <= S_DONE;
            end else begin
              r_o     <= 1'b0;
              r_rem   <= {1'b0, DH};
              r_quo   <= 7'h00;
              r_cnt   <= 3'd0;
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_rem <= w_rem_next;
          r_quo <= {r_quo[5:0], w_ge};
          r_dl  <= {r_dl[6:0], 1'b0};
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            r_q     <= {r_quo, w_ge};
            r_r     <= w_rem_next[7:0];
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Q    = r_q;
  assign R    = r_r;
  assign O    = r_o;
  assign Busy = (r_state == S_RUN);
  assign Done = (r_state == S_DONE);

endmodule

// File: tb/tb_div16by8.sv
// Self-checking bench for div16by8: cycle-level compare against an arithmetic
// model, directed literal cases, mid-run reset and a randomized operand sweep.
module tb_div16by8;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       Start   = 1'b0;
  logic [7:0] DH      = 8'h00;
  logic [7:0] DL      = 8'h00;
  logic [7:0] Divisor = 8'h00;
  logic [7:0] Q;
  logic [7:0] R;
  logic       O;
  logic       Busy;
  logic       Done;

  int n_cmp  = 0;
  int n_err  = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  div16by8 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .Start   (Start),
    .DH      (DH),
    .DL      (DL),
    .Divisor (Divisor),
    .Q       (Q),
    .R       (R),
    .O       (O),
    .Busy    (Busy),
    .Done    (Done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: result from plain division, timing as a busy countdown.
  int         m_left = 0;
  bit         m_done = 1'b0;
  bit         m_o    = 1'b0;
  logic [7:0] m_q    = 8'h00;
  logic [7:0] m_r    = 8'h00;
  logic [7:0] m_pq   = 8'h00;
  logic [7:0] m_pr   = 8'h00;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_o    <= 1'b0;
      m_q    <= 8'h00;
      m_r    <= 8'h00;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1'b1;
        m_q    <= m_pq;
        m_r    <= m_pr;
      end
    end else if (Start) begin
      if (Divisor == 8'h00 || DH >= Divisor) begin
        m_o    <= 1'b1;
        m_q    <= 8'hFF;
        m_r    <= 8'h00;
        m_done <= 1'b1;
      end else begin
        m_o    <= 1'b0;
        m_left <= 8;
        m_pq   <= 8'({DH, DL} / {8'h00, Divisor});
        m_pr   <= 8'({DH, DL} % {8'h00, Divisor});
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en)
      check("cycle", 32'({Busy, Done, O, Q, R}),
            32'({(m_left > 0), m_done, m_o, m_q, m_r}));
  end

  // Called at a negedge with the DUT idle; observes 14 cycles after the start.
  task automatic run_op(input logic [7:0] dh, input logic [7:0] dl, input logic [7:0] dv,
                        input bit scr, output logic [7:0] q, output logic [7:0] r,
                        output logic o, output int busy_cnt, output int done_cnt,
                        output int done_at);
    q = 8'h00; r = 8'h00; o = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    DH = dh; DL = dl; Divisor = dv; Start = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (Busy) busy_cnt++;
      if (Done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          q = Q; r = R; o = O; done_at = i;
        end
      end
      if (scr && (Busy || Done)) begin
        Start   = 1'b1;
        DH      = 8'($urandom);
        DL      = 8'($urandom);
        Divisor = 8'($urandom);
      end else begin
        Start = 1'b0;
      end
    end
    Start = 1'b0;
  endtask

  task automatic check_dir(input string name, input logic [7:0] dh, input logic [7:0] dl,
                           input logic [7:0] dv, input bit scr, input logic [7:0] eq,
                           input logic [7:0] er, input logic eo, input int ebusy,
                           input int edone_at);
    logic [7:0] q, r;
    logic       o;
    int         bc, dc, da;
    run_op(dh, dl, dv, scr, q, r, o, bc, dc, da);
    check({name, "_q"},     32'(q),  32'(eq));
    check({name, "_r"},     32'(r),  32'(er));
    check({name, "_o"},     32'(o),  32'(eo));
    check({name, "_busy"},  32'(bc), 32'(ebusy));
    check({name, "_ndone"}, 32'(dc), 32'd1);
    check({name, "_lat"},   32'(da), 32'(edone_at));
  endtask

  logic [7:0] s_dh, s_dl, s_dv;
  bit         s_err, s_seen;
  int         n_done;

  initial begin
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    check("reset_outputs", 32'({Busy, Done, O, Q, R}), 32'h0);

    check_dir("div1000_7",   8'h03, 8'hE8, 8'h07, 1'b0, 8'h8E, 8'h06, 1'b0, 8, 9);
    check_dir("fe01_ff",     8'hFE, 8'h01, 8'hFF, 1'b0, 8'hFF, 8'h00, 1'b0, 8, 9);
    check_dir("dh_max_ok",   8'h06, 8'hFF, 8'h07, 1'b0, 8'hFF, 8'h06, 1'b0, 8, 9);
    check_dir("div_zero",    8'h12, 8'h34, 8'h00, 1'b0, 8'hFF, 8'h00, 1'b1, 0, 1);
    check_dir("ff_ff",       8'hFF, 8'h5A, 8'hFF, 1'b0, 8'hFF, 8'h00, 1'b1, 0, 1);
    check_dir("dh_eq_div",   8'h07, 8'h00, 8'h07, 1'b0, 8'hFF, 8'h00, 1'b1, 0, 1);
    check_dir("restart_ign", 8'h03, 8'hE8, 8'h07, 1'b1, 8'h8E, 8'h06, 1'b0, 8, 9);
    check_dir("next_accept", 8'h12, 8'h34, 8'h56, 1'b0, 8'h36, 8'h10, 1'b0, 8, 9);

    // Abort in the 4th RUN cycle.
    DH = 8'h03; DL = 8'hE8; Divisor = 8'h07; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_in_run", 32'(Busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 check("abort_outputs", 32'({Busy, Done, O, Q, R}), 32'h0);
    @(negedge clk);
    rst_n  = 1'b1;
    n_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (Done) n_done++;
    end
    check("abort_no_done", 32'(n_done), 32'd0);
    check_dir("after_reset", 8'h03, 8'hE8, 8'h07, 1'b0, 8'h8E, 8'h06, 1'b0, 8, 9);

    for (int k = 0; k < 10000; k++) begin
      s_dh = 8'($urandom);
      s_dl = 8'($urandom);
      s_dv = ($urandom_range(31) == 0) ? 8'h00 : 8'($urandom);
      DH = s_dh; DL = s_dl; Divisor = s_dv; Start = 1'b1;
      s_seen = 1'b0;
      for (int c = 0; c < 20 && !s_seen; c++) begin
        @(negedge clk);
        if (Done) begin
          s_seen = 1'b1;
        end else begin
          Start   = 1'($urandom);
          DH      = 8'($urandom);
          DL      = 8'($urandom);
          Divisor = 8'($urandom);
        end
      end
      if (!s_seen) begin
        check("sweep_done_timeout", 32'd0, 32'd1);
      end else begin
        s_err = (s_dv == 8'h00) || (s_dh >= s_dv);
        check("sweep_o", 32'(O), 32'(s_err));
        if (!s_err) begin
          check("sweep_identity", 32'(Q) * 32'(s_dv) + 32'(R), 32'({s_dh, s_dl}));
          check("sweep_r_lt_div", 32'(R < s_dv), 32'd1);
        end else begin
          check("sweep_err_qr", 32'({Q, R}), 32'h0000FF00);
        end
      end
      Start = 1'($urandom);
      @(negedge clk);
      Start = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
